// File: rtl/fft4_serializer_if.sv
// ---------------------------------------------------------------------------
// fft4_serializer_if
// Bundle of the data/handshake signals around fft4_serializer.
//   i_x0..i_x3 : bins 0..3 of one parallel FFT frame ({real, imag} each)
//   i_valid    : one-cycle frame strobe from the FFT stage
//   o_ready    : serializer has at least one free frame slot
//   o_data     : serialized sample, o_index is its bin number
//   o_last     : marks the 4th sample of a frame
//   o_valid    : o_data valid, i_ready is the downstream accept
//   o_overflow : sticky flag, a frame arrived while both slots were full
// The slave modport is the serializer's view; master is the surrounding
// logic (FFT stage on the input side, next stage on the output side).
// ---------------------------------------------------------------------------
interface fft4_serializer_if #(
  parameter int NB_DATA = 10
);
  logic [2*NB_DATA-1:0] i_x0;
  logic [2*NB_DATA-1:0] i_x1;
  logic [2*NB_DATA-1:0] i_x2;
  logic [2*NB_DATA-1:0] i_x3;
  logic                 i_valid;
  logic                 o_ready;
  logic [2*NB_DATA-1:0] o_data;
  logic [1:0]           o_index;
  logic                 o_last;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_overflow;

  modport master (
    output i_x0, i_x1, i_x2, i_x3, i_valid, i_ready,
    input  o_ready, o_data, o_index, o_last, o_valid, o_overflow
  );

  modport slave (
    input  i_x0, i_x1, i_x2, i_x3, i_valid, i_ready,
    output o_ready, o_data, o_index, o_last, o_valid, o_overflow
  );
endinterface

// File: rtl/fft4_serializer.sv
// ---------------------------------------------------------------------------
// fft4_serializer
// Captures one 4-bin complex frame per accepted i_valid into a two-slot
// ping-pong buffer and streams the bins out one per cycle on a valid/ready
// interface. Frames arriving while both slots are occupied are dropped and
// flagged on the sticky o_overflow (the FFT stage cannot be stalled).
//
// Ports:
//   i_clk : clock, all state changes on the rising edge
//   i_rst : synchronous active-high reset (pointers/counters/flag only)
//   bus   : fft4_serializer_if.slave (frame input, sample stream output,
//           o_ready / o_overflow status)
// Parameters:
//   NB_DATA     : bits per real/imag component (sample is 2*NB_DATA bits)
//   BIT_REVERSE : 0 -> emit bins 0,1,2,3 ; 1 -> emit bins 0,2,1,3
// ---------------------------------------------------------------------------
module fft4_serializer #(
  parameter int NB_DATA     = 10,
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fft4_serializer_if.slave  bus
);

  localparam int NB_SMP = 2 * NB_DATA;

  // Frame storage: slot_q[slot][bin]. Contents are never reset; validity is
  // tracked purely by count_q.
  logic [NB_SMP-1:0] slot_q [2][4];

  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [1:0] count_q,  count_d;
  logic [1:0] pos_q,    pos_d;
  logic       ovf_q,    ovf_d;

  logic       ready;
  logic       valid;
  logic       push;
  logic       drop;
  logic       xfer;
  logic       pop;
  logic [1:0] bin;

  // ---------------------------------------------------------------------
  // Handshake decode. ready comes only from the registered occupancy, so a
  // pop in this cycle does not open a slot for a push in the same cycle.
  // ---------------------------------------------------------------------
  assign ready = (count_q < 2'd2);
  assign valid = (count_q != 2'd0);
  assign push  = bus.i_valid && ready;
  assign drop  = bus.i_valid && !ready;
  assign xfer  = valid && bus.i_ready;
  assign pop   = xfer && (pos_q == 2'd3);

  // Emission position -> bin number (2-bit bit reversal when enabled).
  assign bin = BIT_REVERSE ? {pos_q[0], pos_q[1]} : pos_q;

  // ---------------------------------------------------------------------
  // Frame capture into the slot selected by the write pointer.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (push) begin
      slot_q[wr_sel_q][0] <= bus.i_x0;
      slot_q[wr_sel_q][1] <= bus.i_x1;
      slot_q[wr_sel_q][2] <= bus.i_x2;
      slot_q[wr_sel_q][3] <= bus.i_x3;
    end
  end

  // ---------------------------------------------------------------------
  // Control state register.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      count_q  <= 2'd0;
      pos_q    <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      count_q  <= count_d;
      pos_q    <= pos_d;
      ovf_q    <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------
  always_comb begin
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    count_d  = count_q;
    pos_d    = pos_q;
    ovf_d    = ovf_q | drop;

    if (push) begin
      wr_sel_d = ~wr_sel_q;
    end

    // pos wraps 3 -> 0 naturally; the wrap is also the frame pop.
    if (xfer) begin
      pos_d = pos_q + 2'd1;
    end
    if (pop) begin
      rd_sel_d = ~rd_sel_q;
    end

    // Push and pop together leave the occupancy unchanged (only reachable
    // with count_q == 1, since a push needs a free slot).
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs, decoded from registers only, so they hold under back-pressure.
  // ---------------------------------------------------------------------
  assign bus.o_ready    = ready;
  assign bus.o_valid    = valid;
  assign bus.o_data     = slot_q[rd_sel_q][bin];
  assign bus.o_index    = bin;
  assign bus.o_last     = valid && (pos_q == 2'd3);
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_fft4_serializer.sv
// ---------------------------------------------------------------------------
// tb_fft4_serializer
// Two serializers (natural and bit-reversed order) share one stimulus.
// A frame-level model pushes the expected samples of each accepted frame
// into one queue per instance; every cycle the visible outputs are compared
// with the queue heads and the head is popped when the downstream accepts.
// A short vector table covers the single-frame case, hand-written sequences
// cover stall/overflow, simultaneous push/pop and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_fft4_serializer;

  localparam int NB = 10;
  localparam int NS = 2 * NB;

  typedef struct {
    logic [NS-1:0] data;
    logic [1:0]    idx;
    logic          last;
  } exp_t;

  typedef struct {
    logic          v;
    logic [4*NS-1:0] frame;
    logic          rdy;
    logic          e_valid;
    logic          e_ready;
    logic          e_last;
    logic [NS-1:0] e_data0;
    logic [1:0]    e_idx0;
    logic [NS-1:0] e_data1;
    logic [1:0]    e_idx1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fft4_serializer_if #(.NB_DATA(NB)) bus0 ();
  fft4_serializer_if #(.NB_DATA(NB)) bus1 ();

  fft4_serializer #(.NB_DATA(NB), .BIT_REVERSE(1'b0)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  fft4_serializer #(.NB_DATA(NB), .BIT_REVERSE(1'b1)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   m_count = 0;
  logic m_ovf = 1'b0;
  int   br[4] = '{0, 2, 1, 3};
  vec_t tv[6];

  function automatic logic [4*NS-1:0] mkf(input int base);
    return {NS'(base + 3), NS'(base + 2), NS'(base + 1), NS'(base)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4*NS-1:0] f, input logic rdy);
    bus0.i_valid = v;          bus1.i_valid = v;
    bus0.i_x0 = f[0*NS +: NS]; bus1.i_x0 = f[0*NS +: NS];
    bus0.i_x1 = f[1*NS +: NS]; bus1.i_x1 = f[1*NS +: NS];
    bus0.i_x2 = f[2*NS +: NS]; bus1.i_x2 = f[2*NS +: NS];
    bus0.i_x3 = f[3*NS +: NS]; bus1.i_x3 = f[3*NS +: NS];
    bus0.i_ready = rdy;        bus1.i_ready = rdy;
  endtask

  task automatic push_frame(input logic [4*NS-1:0] f);
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      e.data = f[p*NS +: NS];
      e.idx  = 2'(p);
      e.last = (p == 3);
      q0.push_back(e);
      e.data = f[br[p]*NS +: NS];
      e.idx  = 2'(br[p]);
      e.last = (p == 3);
      q1.push_back(e);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare the
  // register-decoded outputs, then advance the model past the next rising edge.
  task automatic step(input logic v, input logic [4*NS-1:0] f, input logic rdy);
    exp_t e;
    logic can_push;
    @(negedge clk);
    drive(v, f, rdy);
    #1;
    chk("ready0", 32'(bus0.o_ready), 32'(m_count < 2));
    chk("ready1", 32'(bus1.o_ready), 32'(m_count < 2));
    chk("ovf0", 32'(bus0.o_overflow), 32'(m_ovf));
    chk("valid0", 32'(bus0.o_valid), 32'(q0.size() != 0));
    chk("valid1", 32'(bus1.o_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) begin
      chk("data0", 32'(bus0.o_data), 32'(q0[0].data));
      chk("idx0", 32'(bus0.o_index), 32'(q0[0].idx));
      chk("last0", 32'(bus0.o_last), 32'(q0[0].last));
    end else begin
      chk("last0_idle", 32'(bus0.o_last), 32'(0));
    end
    if (q1.size() != 0) begin
      chk("data1", 32'(bus1.o_data), 32'(q1[0].data));
      chk("idx1", 32'(bus1.o_index), 32'(q1[0].idx));
      chk("last1", 32'(bus1.o_last), 32'(q1[0].last));
    end
    can_push = (m_count < 2);
    if (rdy && q0.size() != 0) begin
      e = q0.pop_front();
      $display("dut0 sample data=0x%05h idx=%0d last=%0b", e.data, e.idx, e.last);
      if (e.last) m_count--;
    end
    if (rdy && q1.size() != 0) begin
      e = q1.pop_front();
      $display("dut1 sample data=0x%05h idx=%0d last=%0b", e.data, e.idx, e.last);
    end
    if (v) begin
      if (can_push) begin
        push_frame(f);
        m_count++;
        $display("frame push x0=0x%05h", f[NS-1:0]);
      end else begin
        m_ovf = 1'b1;
        $display("frame drop x0=0x%05h", f[NS-1:0]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    $display("reset applied");
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, '0, 1'b1);
    chk("drain_valid0", 32'(bus0.o_valid), 32'(0));
    chk("drain_valid1", 32'(bus1.o_valid), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single frame 1,2,3,4 pushed at the first edge, i_ready held high.
    tv[0] = '{1'b1, mkf(1), 1'b1, 1'b0, 1'b1, 1'b0, NS'(0), 2'd0, NS'(0), 2'd0};
    tv[1] = '{1'b0, '0,     1'b1, 1'b1, 1'b1, 1'b0, NS'(1), 2'd0, NS'(1), 2'd0};
    tv[2] = '{1'b0, '0,     1'b1, 1'b1, 1'b1, 1'b0, NS'(2), 2'd1, NS'(3), 2'd2};
    tv[3] = '{1'b0, '0,     1'b1, 1'b1, 1'b1, 1'b0, NS'(3), 2'd2, NS'(2), 2'd1};
    tv[4] = '{1'b0, '0,     1'b1, 1'b1, 1'b1, 1'b1, NS'(4), 2'd3, NS'(4), 2'd3};
    tv[5] = '{1'b0, '0,     1'b1, 1'b0, 1'b1, 1'b0, NS'(0), 2'd0, NS'(0), 2'd0};

    drive(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    do_reset();

    // Reset state
    step(1'b0, '0, 1'b1);
    chk("rst_valid", 32'(bus0.o_valid), 32'(0));
    chk("rst_ready", 32'(bus0.o_ready), 32'(1));
    chk("rst_index", 32'(bus0.o_index), 32'(0));
    chk("rst_last", 32'(bus0.o_last), 32'(0));

    // Single frame, both emission orders
    for (int i = 0; i < 6; i++) begin
      step(tv[i].v, tv[i].frame, tv[i].rdy);
      chk($sformatf("tv%0d_valid0", i), 32'(bus0.o_valid), 32'(tv[i].e_valid));
      chk($sformatf("tv%0d_valid1", i), 32'(bus1.o_valid), 32'(tv[i].e_valid));
      chk($sformatf("tv%0d_ready", i), 32'(bus0.o_ready), 32'(tv[i].e_ready));
      chk($sformatf("tv%0d_last0", i), 32'(bus0.o_last), 32'(tv[i].e_last));
      chk($sformatf("tv%0d_last1", i), 32'(bus1.o_last), 32'(tv[i].e_last));
      if (tv[i].e_valid) begin
        chk($sformatf("tv%0d_data0", i), 32'(bus0.o_data), 32'(tv[i].e_data0));
        chk($sformatf("tv%0d_idx0", i), 32'(bus0.o_index), 32'(tv[i].e_idx0));
        chk($sformatf("tv%0d_data1", i), 32'(bus1.o_data), 32'(tv[i].e_data1));
        chk($sformatf("tv%0d_idx1", i), 32'(bus1.o_index), 32'(tv[i].e_idx1));
      end
    end

    // Back-to-back frames every 4 cycles: occupancy never reaches 2
    for (int f = 0; f < 4; f++) begin
      step(1'b1, mkf(16 * f + 16), 1'b1);
      chk("b2b_ready", 32'(bus0.o_ready), 32'(1));
      for (int c = 0; c < 3; c++) begin
        step(1'b0, '0, 1'b1);
        chk("b2b_ready", 32'(bus0.o_ready), 32'(1));
        chk("b2b_valid", 32'(bus0.o_valid), 32'(1));
      end
    end
    drain(6);
    chk("b2b_ovf", 32'(bus0.o_overflow), 32'(0));

    // Downstream stalled: A and B fill both slots, C is dropped
    do_reset();
    step(1'b1, mkf(32'h100), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, mkf(32'h200), 1'b0);
    step(1'b0, '0, 1'b0);
    chk("stall_ready", 32'(bus0.o_ready), 32'(0));
    chk("stall_hold", 32'(bus0.o_data), 32'h100);
    step(1'b1, mkf(32'h300), 1'b0);
    step(1'b0, '0, 1'b0);
    chk("stall_ovf", 32'(bus0.o_overflow), 32'(1));
    chk("stall_hold2", 32'(bus0.o_data), 32'h100);
    drain(10);
    chk("stall_ovf_sticky", 32'(bus0.o_overflow), 32'(1));

    // Push while the last sample of the only frame is accepted
    do_reset();
    step(1'b1, mkf(32'h400), 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);
    step(1'b1, mkf(32'h500), 1'b1);
    chk("pp_last", 32'(bus0.o_last), 32'(1));
    step(1'b0, '0, 1'b1);
    chk("pp_valid", 32'(bus0.o_valid), 32'(1));
    chk("pp_data", 32'(bus0.o_data), 32'h500);
    chk("pp_idx", 32'(bus0.o_index), 32'(0));
    chk("pp_ready", 32'(bus0.o_ready), 32'(1));
    drain(5);

    // Reset in the middle of a frame, with overflow set beforehand
    do_reset();
    step(1'b1, mkf(32'h600), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, mkf(32'h700), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, mkf(32'h800), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("mid_a1", 32'(bus0.o_data), 32'h601);
    do_reset();
    step(1'b0, '0, 1'b1);
    chk("mid_valid", 32'(bus0.o_valid), 32'(0));
    chk("mid_ready", 32'(bus0.o_ready), 32'(1));
    chk("mid_ovf", 32'(bus0.o_overflow), 32'(0));
    step(1'b1, mkf(32'h900), 1'b1);
    step(1'b0, '0, 1'b1);
    chk("mid_fresh_data", 32'(bus0.o_data), 32'h900);
    chk("mid_fresh_idx", 32'(bus0.o_index), 32'(0));
    drain(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft4_serializer.md
# fft4_serializer

Output serializer that sits directly downstream of the 4-point FFT stage. It captures one parallel frame of four complex bins per accepted `i_valid`, buffers up to two frames (ping-pong), and emits the bins one per cycle on a valid/ready stream for the next stage (twiddle multiply / output interface). It also flags frames dropped because the FFT stage cannot be back-pressured.

## Interface
- `NB_DATA`, 10, bits per real/imag component; a sample is `{real, imag}`, 2*NB_DATA bits.
- `BIT_REVERSE`, 0, emission order: 0 = bins 0,1,2,3; 1 = bins 0,2,1,3.
- `i_clk` in 1: clock; all state updates on rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_x0`..`i_x3` in 2*NB_DATA each: bins 0..3 of the input frame.
- `i_valid` in 1: input frame valid (single-cycle pulse per frame from the FFT stage).
- `o_ready` out 1: at least one frame slot free.
- `o_data` out 2*NB_DATA: current output sample.
- `o_index` out 2: bin number of `o_data` (the bin number, not the emission position).
- `o_last` out 1: high with the 4th sample of a frame.
- `o_valid` out 1: `o_data` valid.
- `i_ready` in 1: downstream accepts the sample.
- `o_overflow` out 1: sticky, a frame arrived while full.

## Operation
- Storage: two frame slots of 4 samples each, plus write pointer `wr_sel` (1 bit), read pointer `rd_sel` (1 bit), occupancy `count` (0..2) and position counter `pos` (0..3).
- Push: when `i_valid && o_ready`, store `i_x0..i_x3` into slot `wr_sel`, then toggle `wr_sel`.
- Drop: when `i_valid && !o_ready`, do not store the frame and set `o_overflow`. Stored frames and pointers are unchanged.
- `o_ready` = (`count` < 2), decoded from registered `count`. There is no same-cycle bypass: a pop does not raise `o_ready` in the same cycle.
- Output, combinational from registers:
  - `o_valid` = (`count` != 0).
  - `o_data` = slot[`rd_sel`][`bin(pos)`].
  - `o_index` = `bin(pos)`.
  - `o_last` = `o_valid && pos==3`.
  - `bin(pos)` = `pos` when BIT_REVERSE=0, otherwise `{pos[0],pos[1]}`.
- Transfer: on `o_valid && i_ready`, `pos` increments modulo 4. On `pos==3`, also pop: toggle `rd_sel`, `pos` wraps to 0.
- Count update: push only → +1; pop only → −1; push and pop in the same cycle → unchanged (legal when `count`==1).
- While `o_valid` is high and `i_ready` is low, `o_data`, `o_index` and `o_last` hold stable.
- Reset (also mid-frame): `count`=0, `pos`=0, `wr_sel`=0, `rd_sel`=0, `o_overflow`=0.
  - Resulting outputs: `o_valid`=0, `o_last`=0, `o_ready`=1, `o_index`=0.
  - Buffer contents are not reset; `o_data` is don't-care while `o_valid`=0.
  - Any partially emitted frame is discarded.

## Timing
- Latency: frame pushed at edge k → `o_valid`=1 with bin `bin(0)` during cycle k+1. With `i_ready` held high, the last sample is in cycle k+4.
- Throughput: one sample per cycle. Sustains one input frame every 4 cycles indefinitely with `i_ready`=1.
- `o_ready` reflects state after the previous edge; the upstream 4-cycle frame spacing always finds a slot unless downstream stalls.
- `o_overflow` rises in the cycle after the dropped `i_valid` and stays high until `i_rst`.

## Test plan
- Reset then single frame, BIT_REVERSE=0, `i_ready`=1:
  - Stimulus: x0..x3 = 0x00001, 0x00002, 0x00003, 0x00004 pushed at edge k.
  - Response: cycles k+1..k+4 show `o_data` 1,2,3,4; `o_index` 0,1,2,3; `o_last` only at k+4; `o_valid`=0 at k+5.
- BIT_REVERSE=1, same frame: `o_data` 1,3,2,4; `o_index` 0,2,1,3.
- Back-to-back frames A, B every 4 cycles, `i_ready`=1: 8 consecutive valid cycles A0..A3, B0..B3; `count` never exceeds 1; `o_overflow`=0.
- `i_ready`=0 from start, push frames A then B:
  - `o_ready` falls after B; A0 is held stable on `o_data`.
  - A third frame C is dropped and `o_overflow`=1.
  - Releasing `i_ready` then emits A0..A3, B0..B3; C never appears.
- Simultaneous push/pop:
  - Setup: `count`=1 with `pos`=3 and `i_ready`=1, frame B pushed in the same cycle.
  - Response: `count` stays 1, the next cycle shows B0, no bubble.
- `i_rst` asserted after A1 was emitted:
  - Next cycle: `o_valid`=0, `o_ready`=1, `o_overflow`=0.
  - A fresh frame afterwards emits from its bin 0.
